// File: rtl/rr_grant_arbiter.sv
// rtl/rr_grant_arbiter.sv - four-client round-robin arbiter with hold limit
module rr_grant_arbiter #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       rel,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_vld,
    output logic       tmo
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

    state_t     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] idx_q, idx_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic       tmo_q, tmo_d;

    logic [1:0] sel;
    logic [1:0] cand;
    logic       limit_hit;
    logic       owner_drop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            idx_q   <= 2'b00;
            ptr_q   <= 2'b00;
            cnt_q   <= 8'd0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    // Scan from the farthest offset down so the offset nearest ptr wins.
    always_comb begin
        sel  = ptr_q;
        cand = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            cand = ptr_q + 2'(i);
            if (req[cand]) begin
                sel = cand;
            end
        end
    end

    assign limit_hit  = (HOLD_LIM != 8'd0) && (cnt_q == HOLD_LIM);
    assign owner_drop = rel || !req[idx_q];

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        tmo_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    gnt_d   = 4'b0001 << sel;
                    idx_d   = sel;
                    ptr_d   = sel + 2'd1;
                    cnt_d   = 8'd1;
                end
            end
            GRANT: begin
                if (owner_drop || limit_hit) begin
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                    tmo_d   = limit_hit && !owner_drop;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    assign gnt     = gnt_q;
    assign gnt_idx = idx_q;
    assign gnt_vld = |gnt_q;
    assign tmo     = tmo_q;

endmodule
